// File: rtl/ibutterfly_pipe.sv
// ibutterfly_pipe: inverse radix-2 butterfly, recovers a/b from s=a+b, d=a-b.
// Two-stage valid/ready pipeline with parity flag and saturating error count.
module ibutterfly_pipe #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [(2**N)-1:0]   s_in,
    input  logic [(2**N)-1:0]   d_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [(2**N)-1:0]   a_out,
    output logic [(2**N)-1:0]   b_out,
    output logic                par_err,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                err_clr,
    output logic [CW-1:0]       err_cnt
);

    localparam int W = 2**N;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic         s1_v;
    logic [W:0]   sum1;
    logic [W:0]   dif1;
    logic         s2_v;
    logic         s2_adv;
    logic         acc;
    logic         mv;
    logic         xfer_err;
    logic [W:0]   sx;
    logic [W:0]   dx;
    logic         unused_dif_lsb;

    assign sx = {s_in[W-1], s_in};
    assign dx = {d_in[W-1], d_in};

    assign s2_adv   = !s2_v || out_ready;
    assign in_ready = !s1_v || s2_adv;
    assign acc      = in_valid && in_ready;
    assign mv       = s2_adv && s1_v;
    assign xfer_err = s2_v && out_ready && par_err;

    assign out_valid = s2_v;

    // dif1[0] always matches sum1[0]; parity is taken from sum1 alone
    assign unused_dif_lsb = dif1[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            sum1 <= '0;
            dif1 <= '0;
        end else if (acc) begin
            s1_v <= 1'b1;
            sum1 <= sx + dx;
            dif1 <= sx - dx;
        end else if (mv) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v    <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
            par_err <= 1'b0;
        end else if (mv) begin
            s2_v    <= 1'b1;
            a_out   <= sum1[W:1];
            b_out   <= dif1[W:1];
            par_err <= sum1[0];
        end else if (out_ready) begin
            s2_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= xfer_err ? CNT_ONE : '0;
        end else if (xfer_err && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule
